// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared FSM/owner types, fetch byte-enable constant and 2-way round-robin picker
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
  localparam logic [3:0] FULL_BE = 4'b1111;
  // On contention the port that did not win last goes next; otherwise the lone requester wins.
  function automatic owner_t rr_pick(input logic req_i, input logic req_d, input owner_t last);
    return (req_i && req_d) ? (last == OWN_I ? OWN_D : OWN_I) : (req_d ? OWN_D : OWN_I);
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: Avalon-style memory bus; master drives strobes/address/data, slave returns readdata/waitrequest
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  read;
  logic                  write;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W/8-1:0]   byteenable;
  logic [DATA_W-1:0]     writedata;
  logic [DATA_W-1:0]     readdata;
  logic                  waitrequest;
  modport master (output read, write, addr, byteenable, writedata, input readdata, waitrequest);
  modport slave  (input read, write, addr, byteenable, writedata, output readdata, waitrequest);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one Avalon memory master between fetch and data ports
//   clk, reset_n : clock and asynchronous active-low reset
//   i_bus        : instruction-fetch requester (read only, byteenable forced to all lanes)
//   d_bus        : data requester (read/write; read+write together is a write)
//   m_bus        : memory master; strobes/address/data registered, accepts when waitrequest is low
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  i_bus,
  mem_arbiter_if.slave  d_bus,
  mem_arbiter_if.master m_bus
);
  localparam int BE_W = DATA_W / 8;
  state_t            state_q;
  owner_t            owner_q, last_q, pick_d;
  logic              req_i, req_d, m_read_q, m_write_q, i_done, d_done;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wd_q;
  logic              unused_i;
  assign req_i    = i_bus.read;
  assign req_d    = d_bus.read | d_bus.write;
  assign pick_d   = rr_pick(req_i, req_d, last_q);
  assign unused_i = ^{i_bus.write, i_bus.byteenable, i_bus.writedata};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      last_q    <= OWN_I;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wd_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_i || req_d) begin
          state_q   <= BUSY;
          owner_q   <= pick_d;
          m_read_q  <= pick_d == OWN_I || !d_bus.write;
          m_write_q <= pick_d == OWN_D && d_bus.write;
          addr_q    <= pick_d == OWN_I ? i_bus.addr : d_bus.addr;
          be_q      <= pick_d == OWN_I ? BE_W'(FULL_BE) : d_bus.byteenable;
          wd_q      <= pick_d == OWN_I ? '0 : d_bus.writedata;
        end
        BUSY: if (!m_bus.waitrequest) begin
          state_q   <= RESP;
          m_read_q  <= 1'b0;
          m_write_q <= 1'b0;
          last_q    <= owner_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign m_bus.read       = m_read_q;
  assign m_bus.write      = m_write_q;
  assign m_bus.addr       = addr_q;
  assign m_bus.byteenable = be_q;
  assign m_bus.writedata  = wd_q;
  // Memory readdata is registered, so it is valid exactly in RESP and is passed straight to the owner.
  assign i_done = state_q == RESP && owner_q == OWN_I;
  assign d_done = state_q == RESP && owner_q == OWN_D;
  assign i_bus.waitrequest = !i_done;
  assign d_bus.waitrequest = !d_done;
  assign i_bus.readdata    = i_done ? m_bus.readdata : '0;
  assign d_bus.readdata    = d_done ? m_bus.readdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam logic [31:0] BASE = 32'hBFC0_0000;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ibus ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) dbus ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mbus ();
  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .i_bus(ibus), .d_bus(dbus), .m_bus(mbus)
  );
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  int stall_req = 0;
  bit rand_stall = 0;
  int cnt = 0;
  int rstall = 0;
  int checks = 0;
  int failures = 0;
  logic [5:0] midx;
  function automatic logic [31:0] init_word(input int w);
    return w == 1 ? 32'h3C01_1234 : 32'h1000_0000 + 32'(w) * 32'h0001_0101;
  endfunction
  assign midx = mbus.addr[7:2];
  assign mbus.waitrequest = (mbus.read | mbus.write) && cnt < (rand_stall ? rstall : stall_req);
  initial begin
    for (int w = 0; w < 64; w++) mem[w] = init_word(w);
    mbus.readdata = '0;
    forever begin
      @(posedge clk);
      if (!reset_n) cnt <= 0;
      else if (mbus.read | mbus.write) begin
        if (mbus.waitrequest) cnt <= cnt + 1;
        else begin
          cnt <= 0;
          rstall <= $urandom_range(0, 2);
          if (mbus.write) begin
            for (int b = 0; b < 4; b++)
              if (mbus.byteenable[b]) mem[midx][8*b +: 8] <= mbus.writedata[8*b +: 8];
          end else mbus.readdata <= mem[midx];
        end
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_all();
    ibus.read = 0; ibus.write = 0; ibus.addr = 0; ibus.byteenable = 0; ibus.writedata = 0;
    dbus.read = 0; dbus.write = 0; dbus.addr = 0; dbus.byteenable = 0; dbus.writedata = 0;
  endtask
  task automatic do_reset();
    reset_n = 0;
    idle_all();
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1;
    step();
  endtask
  task automatic wait_ack(input bit is_d, input int limit, output int cyc);
    cyc = 0;
    @(negedge clk);
    while ((is_d ? dbus.waitrequest : ibus.waitrequest) && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask
  task automatic run_port(input bit is_d, input int n);
    int gap, w, cyc, foreign;
    bit wr, done;
    logic [3:0] be;
    logic [31:0] wd;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 2);
      w = $urandom_range(0, 15);
      wr = is_d && ($urandom_range(0, 1) == 1);
      be = 4'($urandom_range(1, 15));
      wd = $urandom;
      cyc = 0;
      foreign = 0;
      done = 0;
      repeat (gap) step();
      if (is_d) begin
        dbus.addr = BASE + 32'(4 * w); dbus.read = !wr; dbus.write = wr;
        dbus.byteenable = be; dbus.writedata = wd;
      end else begin
        ibus.addr = BASE + 32'(4 * w); ibus.read = 1;
      end
      while (!done && cyc < 40) begin
        @(negedge clk);
        check("rnd_excl", 32'(ibus.waitrequest | dbus.waitrequest), 1);
        done = is_d ? !dbus.waitrequest : !ibus.waitrequest;
        if (!done && (is_d ? !ibus.waitrequest : !dbus.waitrequest)) foreign++;
        cyc++;
      end
      check(is_d ? "rnd_d_done" : "rnd_i_done", 32'(done), 1);
      check("rnd_fair", 32'(foreign <= 1), 1);
      if (wr) begin
        for (int b = 0; b < 4; b++) if (be[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
      end else check(is_d ? "rnd_d_rdata" : "rnd_i_rdata", is_d ? dbus.readdata : ibus.readdata, ref_mem[w]);
      @(posedge clk);
      #1;
      if (is_d) begin dbus.read = 0; dbus.write = 0; end
      else ibus.read = 0;
    end
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int cyc;
    int d_at[$];
    int i_at[$];
    for (int w = 0; w < 64; w++) ref_mem[w] = init_word(w);
    idle_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mread", 32'(mbus.read), 0);
    check("rst_mwrite", 32'(mbus.write), 0);
    check("rst_maddr", mbus.addr, 0);
    check("rst_mbe", 32'(mbus.byteenable), 0);
    check("rst_mwd", mbus.writedata, 0);
    check("rst_iwait", 32'(ibus.waitrequest), 1);
    check("rst_dwait", 32'(dbus.waitrequest), 1);
    check("rst_irdata", ibus.readdata, 0);
    check("rst_drdata", dbus.readdata, 0);
    reset_n = 1;
    step();
    ibus.read = 1; ibus.addr = BASE + 4;
    @(negedge clk);
    check("t1_c0_mread", 32'(mbus.read), 0);
    @(negedge clk);
    check("t1_c1_mread", 32'(mbus.read), 1);
    check("t1_c1_be", 32'(mbus.byteenable), 32'hF);
    check("t1_c1_addr", mbus.addr, BASE + 4);
    check("t1_c1_iwait", 32'(ibus.waitrequest), 1);
    @(negedge clk);
    check("t1_c2_iwait", 32'(ibus.waitrequest), 0);
    check("t1_c2_rdata", ibus.readdata, 32'h3C01_1234);
    check("t1_c2_mread", 32'(mbus.read), 0);
    step();
    ibus.read = 0;
    @(negedge clk);
    check("t1_c3_iwait", 32'(ibus.waitrequest), 1);
    step();
    dbus.write = 1; dbus.addr = BASE + 16; dbus.writedata = 32'hDEAD_BEEF; dbus.byteenable = 4'hF;
    wait_ack(1, 20, cyc);
    check("t2_wr_lat", 32'(cyc), 2);
    check("t2_wr_iwait", 32'(ibus.waitrequest), 1);
    ref_mem[4] = 32'hDEAD_BEEF;
    step();
    dbus.write = 0; dbus.read = 1;
    wait_ack(1, 20, cyc);
    check("t2_rd_lat", 32'(cyc), 2);
    check("t2_rd_data", dbus.readdata, ref_mem[4]);
    check("t2_rd_iwait", 32'(ibus.waitrequest), 1);
    step();
    dbus.read = 0;
    do_reset();
    ibus.read = 1; ibus.addr = BASE + 8;
    dbus.read = 1; dbus.addr = BASE + 12;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (!dbus.waitrequest) d_at.push_back(c);
      if (!ibus.waitrequest) i_at.push_back(c);
      if (c == 2) check("t3_d_rdata", dbus.readdata, ref_mem[3]);
      if (c == 5) check("t3_i_rdata", ibus.readdata, ref_mem[2]);
    end
    check("t3_d_count", 32'(d_at.size()), 2);
    check("t3_i_count", 32'(i_at.size()), 1);
    check("t3_d_first", 32'(d_at.size() > 0 ? d_at[0] : -1), 2);
    check("t3_i_first", 32'(i_at.size() > 0 ? i_at[0] : -1), 5);
    check("t3_d_second", 32'(d_at.size() > 1 ? d_at[1] : -1), 8);
    step();
    idle_all();
    stall_req = 3;
    step();
    ibus.read = 1; ibus.addr = BASE + 20;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        check("t4_mread", 32'(mbus.read), 1);
        check("t4_maddr", mbus.addr, BASE + 20);
      end
      if (c == 1) ibus.addr = BASE + 40;
      if (c < 5) check("t4_iwait_hi", 32'(ibus.waitrequest), 1);
      else begin
        check("t4_iwait_lo", 32'(ibus.waitrequest), 0);
        check("t4_rdata", ibus.readdata, ref_mem[5]);
      end
    end
    step();
    ibus.read = 0;
    stall_req = 0;
    step();
    ibus.read = 1; ibus.addr = BASE + 24;
    @(negedge clk);
    @(negedge clk);
    check("t5_busy_mread", 32'(mbus.read), 1);
    #1 reset_n = 0;
    #1;
    check("t5_rst_mread", 32'(mbus.read), 0);
    check("t5_rst_iwait", 32'(ibus.waitrequest), 1);
    check("t5_rst_dwait", 32'(dbus.waitrequest), 1);
    ibus.read = 0;
    @(negedge clk);
    check("t5_rst_hold_iwait", 32'(ibus.waitrequest), 1);
    reset_n = 1;
    step();
    ibus.read = 1; ibus.addr = BASE + 28;
    wait_ack(0, 20, cyc);
    check("t5_lat", 32'(cyc), 2);
    check("t5_rdata", ibus.readdata, ref_mem[7]);
    step();
    ibus.read = 0;
    rand_stall = 1;
    step();
    fork
      run_port(0, 40);
      run_port(1, 40);
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
